// File: rtl/usart_cmd_ctrl.sv
// Command-frame decoder behind a UART receiver: HEADER, ADDR, DHI, DLO, CHK frames
// write one of four 16-bit config registers, with checksum/address checking and inter-byte timeout.
module usart_cmd_ctrl #(
    parameter logic [7:0]  HEADER      = 8'h55,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [15:0] GATE_RST    = 16'h03E8
) (
    input  logic        clkb,
    input  logic        rst_n,
    input  logic        rx_done,
    input  logic [7:0]  rxdata,
    output logic [15:0] cfg_gate,
    output logic [15:0] cfg_chsel,
    output logic [15:0] cfg_ctrl,
    output logic [15:0] cfg_aux,
    output logic        cfg_we,
    output logic [1:0]  cfg_addr,
    output logic        meas_start,
    output logic        frame_err,
    output logic        frame_tmo,
    output logic [7:0]  ok_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_ADDR = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic [7:0]         r_addr;
    logic [7:0]         r_dhi;
    logic [7:0]         r_dlo;
    logic               w_tmo_hit;
    logic               w_chk_evt;
    logic [7:0]         w_sum;
    logic [15:0]        w_wdata;
    logic               w_we;
    logic               w_err;
    logic               w_start;

    // An arriving byte always beats the timeout in the same cycle
    assign w_tmo_hit = (r_state != S_HDR) && !rx_done && (r_tmo_cnt == TIMEOUT_CYC);

    // State register
    always_ff @(posedge clkb) begin
        if (!rst_n) r_state <= S_HDR;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (rx_done) begin
            case (r_state)
                S_HDR:   w_state_nxt = (rxdata == HEADER) ? S_ADDR : S_HDR;
                S_ADDR:  w_state_nxt = S_DHI;
                S_DHI:   w_state_nxt = S_DLO;
                S_DLO:   w_state_nxt = S_CHK;
                S_CHK:   w_state_nxt = S_HDR;
                default: w_state_nxt = S_HDR;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = S_HDR;
        end
    end

    // Frame evaluation; results are registered into the pulse outputs below
    always_comb begin
        w_chk_evt = rx_done && (r_state == S_CHK);
        w_sum     = 8'(r_addr + r_dhi + r_dlo);
        w_wdata   = {r_dhi, r_dlo};
        w_we      = w_chk_evt && (rxdata == w_sum) && (r_addr[7:2] == 6'd0);
        w_err     = w_chk_evt && !w_we;
        w_start   = w_we && (r_addr[1:0] == 2'd2) && r_dlo[1];
    end

    always_ff @(posedge clkb) begin
        if (!rst_n) begin
            r_tmo_cnt  <= '0;
            r_addr     <= '0;
            r_dhi      <= '0;
            r_dlo      <= '0;
            cfg_gate   <= GATE_RST;
            cfg_chsel  <= '0;
            cfg_ctrl   <= '0;
            cfg_aux    <= '0;
            cfg_we     <= 1'b0;
            cfg_addr   <= '0;
            meas_start <= 1'b0;
            frame_err  <= 1'b0;
            frame_tmo  <= 1'b0;
            ok_cnt     <= '0;
        end else begin
            if (rx_done || r_state == S_HDR)  r_tmo_cnt <= '0;
            else if (r_tmo_cnt != TIMEOUT_CYC) r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);

            if (rx_done) begin
                case (r_state)
                    S_ADDR:  r_addr <= rxdata;
                    S_DHI:   r_dhi  <= rxdata;
                    S_DLO:   r_dlo  <= rxdata;
                    default: ;
                endcase
            end

            cfg_we     <= w_we;
            meas_start <= w_start;
            frame_err  <= w_err;
            frame_tmo  <= w_tmo_hit;

            if (w_we) begin
                cfg_addr <= r_addr[1:0];
                ok_cnt   <= ok_cnt + 8'd1;
                case (r_addr[1:0])
                    2'd0:    cfg_gate  <= w_wdata;
                    2'd1:    cfg_chsel <= w_wdata;
                    2'd2:    cfg_ctrl  <= w_wdata & 16'hFFFD;
                    default: cfg_aux   <= w_wdata;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usart_cmd_ctrl.sv
// Scoreboard bench for usart_cmd_ctrl: expected pulses are queued as frames are sent
// and matched against DUT pulses sampled on the falling edge.
module tb_usart_cmd_ctrl;

    localparam int unsigned TMO = 40;

    logic        clkb = 1'b0;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  rxdata;
    logic [15:0] cfg_gate, cfg_chsel, cfg_ctrl, cfg_aux;
    logic        cfg_we, meas_start, frame_err, frame_tmo;
    logic [1:0]  cfg_addr;
    logic [7:0]  ok_cnt;

    usart_cmd_ctrl #(
        .HEADER      (8'h55),
        .TIMEOUT_CYC (16'(TMO)),
        .GATE_RST    (16'h03E8)
    ) dut (
        .clkb       (clkb),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rxdata     (rxdata),
        .cfg_gate   (cfg_gate),
        .cfg_chsel  (cfg_chsel),
        .cfg_ctrl   (cfg_ctrl),
        .cfg_aux    (cfg_aux),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .meas_start (meas_start),
        .frame_err  (frame_err),
        .frame_tmo  (frame_tmo),
        .ok_cnt     (ok_cnt)
    );

    always #5 clkb = ~clkb;

    // kind: 0 = write, 1 = frame error, 2 = timeout
    typedef struct {
        int         kind;
        logic [1:0] addr;
        logic       start;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          fails   = 0;
    logic [15:0] m_reg[4];
    logic [7:0]  m_ok;

    // Every pulse cycle must match the oldest queued expectation
    always @(negedge clkb) begin
        if (cfg_we || frame_err || frame_tmo || meas_start) begin
            vectors++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse got we=%b err=%b tmo=%b start=%b exp none",
                         cfg_we, frame_err, frame_tmo, meas_start);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cfg_we !== (e.kind == 0) || frame_err !== (e.kind == 1) ||
                    frame_tmo !== (e.kind == 2) || meas_start !== e.start ||
                    (e.kind == 0 && cfg_addr !== e.addr)) begin
                    fails++;
                    $display("FAIL pulse got we=%b err=%b tmo=%b start=%b addr=%0d exp kind=%0d start=%b addr=%0d",
                             cfg_we, frame_err, frame_tmo, meas_start, cfg_addr, e.kind, e.start, e.addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clkb);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rxdata  = b;
        @(posedge clkb);
        #1;
        rx_done = 1'b0;
        rxdata  = 8'h00;
    endtask

    task automatic model_reset();
        m_reg[0] = 16'h03E8;
        m_reg[1] = 16'h0000;
        m_reg[2] = 16'h0000;
        m_reg[3] = 16'h0000;
        m_ok     = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c, input int gap);
        logic [7:0] s;
        s = a + h + l;
        send_byte(8'h55); idle(gap);
        send_byte(a);     idle(gap);
        send_byte(h);     idle(gap);
        send_byte(l);     idle(gap);
        if (c == s && a[7:2] == 6'd0) begin
            q.push_back('{0, a[1:0], (a[1:0] == 2'd2) && l[1]});
            m_reg[a[1:0]] = (a[1:0] == 2'd2) ? ({h, l} & 16'hFFFD) : {h, l};
            m_ok = m_ok + 8'd1;
        end else begin
            q.push_back('{1, 2'd0, 1'b0});
        end
        send_byte(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        model_reset();
        vectors++;
        if (cfg_gate !== 16'h03E8 || cfg_chsel !== 16'h0 || cfg_ctrl !== 16'h0 || cfg_aux !== 16'h0) begin
            fails++;
            $display("FAIL reset_regs got %h %h %h %h exp 03e8 0000 0000 0000", cfg_gate, cfg_chsel, cfg_ctrl, cfg_aux);
        end
        vectors++;
        if (cfg_we !== 1'b0 || meas_start !== 1'b0 || frame_err !== 1'b0 || frame_tmo !== 1'b0 ||
            cfg_addr !== 2'd0 || ok_cnt !== 8'h00) begin
            fails++;
            $display("FAIL reset_pulses got we=%b st=%b err=%b tmo=%b addr=%0d ok=%h exp all zero",
                     cfg_we, meas_start, frame_err, frame_tmo, cfg_addr, ok_cnt);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_write_gate();
        send_frame(8'h00, 8'h07, 8'hD0, 8'hD7, 0);
        idle(2);
        vectors++;
        if (cfg_gate !== 16'h07D0) begin
            fails++; $display("FAIL write_gate got %h exp 07d0", cfg_gate);
        end
        vectors++;
        if (ok_cnt !== m_ok) begin
            fails++; $display("FAIL write_gate_okcnt got %h exp %h", ok_cnt, m_ok);
        end
    endtask

    task automatic test_meas_start();
        send_frame(8'h02, 8'h00, 8'h03, 8'h05, 0);
        idle(2);
        vectors++;
        if (cfg_ctrl !== 16'h0001 || cfg_ctrl[1] !== 1'b0) begin
            fails++; $display("FAIL meas_ctrl got %h exp 0001", cfg_ctrl);
        end
    endtask

    task automatic test_bad_frames();
        send_frame(8'h01, 8'h00, 8'h04, 8'h00, 0);
        send_frame(8'h05, 8'h00, 8'h00, 8'h05, 1);
        idle(2);
        vectors++;
        if (cfg_chsel !== m_reg[1] || ok_cnt !== m_ok) begin
            fails++; $display("FAIL bad_frames got chsel=%h ok=%h exp chsel=%h ok=%h", cfg_chsel, ok_cnt, m_reg[1], m_ok);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h12);
        q.push_back('{2, 2'd0, 1'b0});
        idle(TMO + 10);
        send_frame(8'h03, 8'hAB, 8'hCD, 8'h7B, 0);
        idle(2);
        vectors++;
        if (cfg_aux !== 16'hABCD) begin
            fails++; $display("FAIL timeout_aux got %h exp abcd", cfg_aux);
        end
        // Bytes arriving exactly on the timeout cycle are still consumed
        send_frame(8'h01, 8'h12, 8'h34, 8'h47, TMO);
        idle(2);
        vectors++;
        if (cfg_chsel !== 16'h1234) begin
            fails++; $display("FAIL timeout_edge got %h exp 1234", cfg_chsel);
        end
    endtask

    task automatic test_garbage_and_midreset();
        send_byte(8'h00); send_byte(8'hFF);
        send_frame(8'h01, 8'h00, 8'h02, 8'h03, 0);
        idle(2);
        vectors++;
        if (cfg_chsel !== 16'h0002) begin
            fails++; $display("FAIL garbage_chsel got %h exp 0002", cfg_chsel);
        end
        send_byte(8'h55); send_byte(8'h01);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        model_reset();
        vectors++;
        if (cfg_gate !== 16'h03E8 || cfg_chsel !== 16'h0 || cfg_ctrl !== 16'h0 || cfg_aux !== 16'h0 || ok_cnt !== 8'h00) begin
            fails++;
            $display("FAIL midreset got %h %h %h %h ok=%h exp 03e8 0 0 0 ok=00", cfg_gate, cfg_chsel, cfg_ctrl, cfg_aux, ok_cnt);
        end
        send_frame(8'h00, 8'h11, 8'h22, 8'h33, 0);
        idle(2);
        vectors++;
        if (cfg_gate !== 16'h1122 || ok_cnt !== 8'h01) begin
            fails++; $display("FAIL after_reset got gate=%h ok=%h exp gate=1122 ok=01", cfg_gate, ok_cnt);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h02, 8'h80, 8'h06, 8'h88, 0);
        send_frame(8'h03, 8'h00, 8'h01, 8'h04, 0);
        send_frame(8'h01, 8'h00, 8'h01, 8'h00, 0);
        idle(2);
        vectors++;
        if (cfg_ctrl !== m_reg[2] || cfg_aux !== m_reg[3] || ok_cnt !== m_ok) begin
            fails++;
            $display("FAIL back_to_back got ctrl=%h aux=%h ok=%h exp ctrl=%h aux=%h ok=%h",
                     cfg_ctrl, cfg_aux, ok_cnt, m_reg[2], m_reg[3], m_ok);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = 8'(i);
            send_frame(8'h03, d, 8'h5A, 8'(8'h03 + d + 8'h5A), 0);
            if (i == 254) begin
                idle(1);
                vectors++;
                if (ok_cnt !== 8'hFF) begin
                    fails++; $display("FAIL wrap_ff got %h exp ff", ok_cnt);
                end
            end
        end
        idle(2);
        vectors++;
        if (ok_cnt !== 8'h00 || cfg_aux !== 16'hFF5A) begin
            fails++; $display("FAIL wrap got ok=%h aux=%h exp ok=00 aux=ff5a", ok_cnt, cfg_aux);
        end
    endtask

    task automatic check_drained(input string name);
        idle(2);
        vectors++;
        if (q.size() !== 0) begin
            fails++; $display("FAIL %s_drain got %0d pending exp 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rxdata  = 8'h00;
        model_reset();
        @(posedge clkb);
        #1;
        test_reset();                check_drained("reset");
        test_write_gate();           check_drained("write_gate");
        test_meas_start();           check_drained("meas_start");
        test_bad_frames();           check_drained("bad_frames");
        test_timeout();              check_drained("timeout");
        test_garbage_and_midreset(); check_drained("garbage");
        test_back_to_back();         check_drained("back_to_back");
        test_wrap();                 check_drained("wrap");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/usart_cmd_ctrl.md
USART_CMD_CTRL -- requirements
Module: usart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'h55, frame start byte.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16'd50000, maximum clkb cycles between bytes inside a frame.
REQ-003 The block SHALL have parameter GATE_RST, default 16'h03E8, reset value of cfg_gate.
REQ-004 The block SHALL have ports, one per line:
  clkb  input  1  system clock, all logic on rising edge
  rst_n  input  1  reset, synchronous, active-low
  rx_done  input  1  one-cycle pulse from the UART receiver, byte valid
  rxdata  input  8  received byte, valid while rx_done=1
  cfg_gate  output  16  gate-time register (reg 0)
  cfg_chsel  output  16  channel-select register (reg 1)
  cfg_ctrl  output  16  control register (reg 2); bit0 = meas_en
  cfg_aux  output  16  auxiliary register (reg 3)
  cfg_we  output  1  one-cycle pulse, a register was written
  cfg_addr  output  2  address of last write, valid with cfg_we
  meas_start  output  1  one-cycle start pulse
  frame_err  output  1  one-cycle pulse, checksum or address error
  frame_tmo  output  1  one-cycle pulse, inter-byte timeout
  ok_cnt  output  8  count of accepted frames, wraps 8'hFF->8'h00

Function
REQ-005 Frame format SHALL be 5 bytes: HEADER, ADDR, DHI, DLO, CHK; CHK = (ADDR+DHI+DLO) mod 256.
REQ-006 FSM states SHALL be S_HDR, S_ADDR, S_DHI, S_DLO, S_CHK; bytes are consumed only in cycles with rx_done=1.
REQ-007 S_HDR: rx_done with rxdata==HEADER -> S_ADDR; any other byte SHALL be discarded, state unchanged.
REQ-008 S_ADDR/S_DHI/S_DLO: rx_done SHALL latch the byte and advance to the next state; HEADER value in these states is treated as data (no resync).
REQ-009 S_CHK: rx_done SHALL return FSM to S_HDR in the same edge and evaluate the frame.
REQ-010 Frame accepted iff CHK matches and ADDR[7:2]==0; then, on the cycle after the CHK rx_done, register ADDR[1:0] SHALL take {DHI,DLO}, cfg_we=1, cfg_addr=ADDR[1:0], ok_cnt increments.
REQ-011 Frame rejected SHALL produce frame_err=1 one cycle after the CHK rx_done, no register change, no cfg_we, ok_cnt unchanged.
REQ-012 Write to reg 2 SHALL store {DHI,DLO} with bit1 forced to 0; if written bit1=1, meas_start=1 in the same cycle as cfg_we.
REQ-013 An rx_done in the cycle carrying cfg_we/frame_err SHALL be processed normally in S_HDR (back-to-back frames supported).
REQ-014 Timeout counter SHALL clear on every rx_done and in S_HDR, increment otherwise, saturating at TIMEOUT_CYC.
REQ-015 When counter reaches TIMEOUT_CYC outside S_HDR, FSM SHALL go to S_HDR and frame_tmo SHALL pulse exactly once; partial frame discarded.
REQ-016 rx_done coinciding with the timeout cycle SHALL win: byte is consumed, no timeout.
REQ-017 cfg_we, meas_start, frame_err, frame_tmo SHALL never be high for more than one consecutive cycle per event; frame_err and cfg_we mutually exclusive.

Reset
REQ-018 rst_n=0 at a clkb edge SHALL set: FSM S_HDR, timeout counter 0, cfg_gate=GATE_RST, cfg_chsel=0, cfg_ctrl=0, cfg_aux=0, cfg_addr=0, ok_cnt=0, all pulse outputs 0.
REQ-019 Reset mid-frame SHALL discard the partial frame; first byte after release is evaluated in S_HDR.

Verification
REQ-020 Bytes 55 00 07 D0 D7 -> cfg_gate=16'h07D0, cfg_we one cycle with cfg_addr=0, ok_cnt=1.
REQ-021 Bytes 55 02 00 03 05 -> cfg_ctrl=16'h0001, meas_start and cfg_we pulse together; cfg_ctrl bit1 reads 0.
REQ-022 Bytes 55 01 00 04 00 (bad CHK) and 55 05 00 00 05 (bad ADDR) -> frame_err pulse each, cfg_chsel unchanged, ok_cnt unchanged.
REQ-023 55 00 12 then no rx_done for TIMEOUT_CYC cycles -> single frame_tmo pulse; then 55 03 AB CD 7B -> cfg_aux=16'hABCD.
REQ-024 Garbage 00 FF 55 01 00 02 03 -> leading bytes ignored, cfg_chsel=16'h0002; rst_n=0 after 55 01 -> all outputs at reset values, next full frame accepted.
REQ-025 256 accepted frames -> ok_cnt wraps to 8'h00.
